// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: sized loads/stores on a req/ack bus with stall and timeout.
// Optional MEM_ALIGN_CHECK_EN reports misaligned half/word accesses instead of issuing them.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [1:0]  Size_i,
  input  logic        Unsigned_i,
  input  logic [31:0] Addr_i,
  input  logic [31:0] StoreData_i,
  input  logic        RegWrite_i,
  output logic        RegWrite_o,
  output logic [31:0] MemData_o,
  output logic        mem_stall_o,
  output logic        mem_err_o,
  output logic        misalign_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic          op;
  logic          mis_c;
  logic [1:0]    a_lo;
  logic [3:0]    be_c;
  logic [31:0]   wdata_c;
  logic [1:0]    size_q;
  logic          uns_q;
  logic          ld_q;
  logic [1:0]    lo_q;
  logic          err_q;
  logic          mis_q;
  logic [CW-1:0] cnt_q;
  logic          tmo;
  logic [31:0]   lane;
  logic [31:0]   ldata;

  assign op  = MemRead_i | MemWrite_i;
  assign tmo = (cnt_q == CNT_LAST);

`ifdef MEM_ALIGN_CHECK_EN
  assign a_lo  = Addr_i[1:0];
  assign mis_c = ((Size_i == 2'b01) && Addr_i[0]) ||
                 (Size_i[1] && (Addr_i[1:0] != 2'b00));
`else
  // Without checking, misaligned half/word are silently aligned down
  always_comb begin
    a_lo = Addr_i[1:0];
    if (Size_i == 2'b01)
      a_lo[0] = 1'b0;
    else if (Size_i[1])
      a_lo = 2'b00;
  end
  assign mis_c = 1'b0;
`endif

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = StoreData_i;
    unique case (1'b1)
      (Size_i == 2'b00): begin
        be_c    = 4'b0001 << a_lo;
        wdata_c = {4{StoreData_i[7:0]}};
      end
      (Size_i == 2'b01): begin
        be_c    = 4'b0011 << {a_lo[1], 1'b0};
        wdata_c = {2{StoreData_i[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = StoreData_i;
      end
    endcase
  end

  always_comb begin
    lane  = bus_rdata_i >> {lo_q, 3'b000};
    ldata = lane;
    unique case (1'b1)
      (size_q == 2'b00):
        ldata = uns_q ? {24'h0, lane[7:0]}
                      : {{24{lane[7]}}, lane[7:0]};
      (size_q == 2'b01):
        ldata = uns_q ? {16'h0, lane[15:0]}
                      : {{16{lane[15]}}, lane[15:0]};
      default:
        ldata = bus_rdata_i;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mem_stall_o = 1'b0;
    case (state_q)
      IDLE: begin
        mem_stall_o = op;
        if (op)
          state_d = mis_c ? DONE : BUSY;
      end
      BUSY: begin
        mem_stall_o = 1'b1;
        if (bus_ack_i || tmo)
          state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_err_o  = (state_q == DONE) & err_q;
  assign misalign_o = (state_q == DONE) & mis_q;
  assign RegWrite_o = RegWrite_i & ~((state_q == DONE) & (err_q | mis_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= 32'h0;
      bus_be_o    <= 4'h0;
      bus_wdata_o <= 32'h0;
      MemData_o   <= 32'h0;
      cnt_q       <= '0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      ld_q        <= 1'b0;
      lo_q        <= 2'b00;
      err_q       <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          err_q <= 1'b0;
          mis_q <= 1'b0;
          if (op) begin
            if (mis_c) begin
              mis_q     <= 1'b1;
              MemData_o <= 32'h0;
            end else begin
              bus_req_o   <= 1'b1;
              bus_we_o    <= MemWrite_i;
              bus_addr_o  <= {Addr_i[31:2], 2'b00};
              bus_be_o    <= be_c;
              bus_wdata_o <= wdata_c;
              size_q      <= Size_i;
              uns_q       <= Unsigned_i;
              ld_q        <= ~MemWrite_i;
              lo_q        <= a_lo;
            end
          end
        end
        BUSY: begin
          if (bus_ack_i) begin
            bus_req_o <= 1'b0;
            cnt_q     <= '0;
            if (ld_q)
              MemData_o <= ldata;
          end else if (tmo) begin
            bus_req_o <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b1;
            MemData_o <= 32'h0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit.
// Define MEM_ALIGN_CHECK_EN here too when the design is built with it.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MemRead_i = 1'b0;
  logic        MemWrite_i = 1'b0;
  logic [1:0]  Size_i = 2'b00;
  logic        Unsigned_i = 1'b0;
  logic [31:0] Addr_i = 32'h0;
  logic [31:0] StoreData_i = 32'h0;
  logic        RegWrite_i = 1'b0;
  logic        RegWrite_o;
  logic [31:0] MemData_o;
  logic        mem_stall_o;
  logic        mem_err_o;
  logic        misalign_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i = 1'b0;
  logic [31:0] bus_rdata_i = 32'h0;

  int errors = 0;
  int checks = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .Size_i(Size_i), .Unsigned_i(Unsigned_i),
    .Addr_i(Addr_i), .StoreData_i(StoreData_i),
    .RegWrite_i(RegWrite_i), .RegWrite_o(RegWrite_o),
    .MemData_o(MemData_o), .mem_stall_o(mem_stall_o),
    .mem_err_o(mem_err_o), .misalign_o(misalign_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o),
    .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i),
    .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic rd, input logic wr,
                        input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] d);
    MemRead_i   = rd;
    MemWrite_i  = wr;
    Size_i      = sz;
    Unsigned_i  = uns;
    Addr_i      = a;
    StoreData_i = d;
    RegWrite_i  = rd;
  endtask

  task automatic set_idle;
    set_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #10;
    checks++;
    if ({bus_req_o, bus_we_o, bus_be_o, mem_stall_o, mem_err_o, misalign_o} !== 9'h0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=0",
               {bus_req_o, bus_we_o, bus_be_o, mem_stall_o, mem_err_o, misalign_o});
    end
    checks++;
    if ({bus_addr_o, bus_wdata_o, MemData_o} !== 96'h0) begin
      errors++;
      $display("FAIL reset_data addr=%h wdata=%h mdata=%h exp=0",
               bus_addr_o, bus_wdata_o, MemData_o);
    end
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_lb;
    set_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
    #1;
    checks++;
    if (mem_stall_o !== 1'b1) begin
      errors++; $display("FAIL lb_stall_idle got=%b exp=1", mem_stall_o);
    end
    tick;
    checks++;
    if ({bus_req_o, bus_we_o, bus_be_o, mem_stall_o} !== 7'b1_0_1000_1 || bus_addr_o !== 32'h100) begin
      errors++;
      $display("FAIL lb_busy req=%b we=%b be=%b stall=%b addr=%h exp 1 0 1000 1 00000100",
               bus_req_o, bus_we_o, bus_be_o, mem_stall_o, bus_addr_o);
    end
    bus_rdata_i = 32'h80AA_BBCC;
    bus_ack_i   = 1'b1;
    tick;
    bus_ack_i = 1'b0;
    checks++;
    if (MemData_o !== 32'hFFFF_FF80) begin
      errors++; $display("FAIL lb_data got=%h exp=ffffff80", MemData_o);
    end
    checks++;
    if ({mem_stall_o, bus_req_o, RegWrite_o} !== 3'b001) begin
      errors++;
      $display("FAIL lb_done stall=%b req=%b rw=%b exp 0 0 1", mem_stall_o, bus_req_o, RegWrite_o);
    end
    tick;
    set_idle;
  endtask

  task automatic test_sh;
    set_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h1234_ABCD);
    tick;
    checks++;
    if (bus_be_o !== 4'b1100 || bus_wdata_o !== 32'hABCD_ABCD ||
        bus_we_o !== 1'b1 || bus_addr_o !== 32'h200 || bus_req_o !== 1'b1) begin
      errors++;
      $display("FAIL sh_bus be=%b wdata=%h we=%b addr=%h req=%b exp 1100 abcdabcd 1 00000200 1",
               bus_be_o, bus_wdata_o, bus_we_o, bus_addr_o, bus_req_o);
    end
    bus_ack_i = 1'b1;
    tick;
    bus_ack_i = 1'b0;
    checks++;
    if ({mem_stall_o, bus_req_o, mem_err_o, MemData_o} !== {3'b000, 32'hFFFF_FF80}) begin
      errors++;
      $display("FAIL sh_done stall=%b req=%b err=%b mdata=%h exp 0 0 0 ffffff80",
               mem_stall_o, bus_req_o, mem_err_o, MemData_o);
    end
    tick;
    set_idle;
  endtask

  task automatic test_timeout;
    set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
    tick;
    for (int i = 1; i < 16; i++) tick;
    checks++;
    if ({bus_req_o, mem_stall_o, mem_err_o} !== 3'b110) begin
      errors++;
      $display("FAIL to_last_busy req=%b stall=%b err=%b exp 1 1 0", bus_req_o, mem_stall_o, mem_err_o);
    end
    tick;
    checks++;
    if ({mem_err_o, RegWrite_o, bus_req_o, mem_stall_o} !== 4'b1000) begin
      errors++;
      $display("FAIL to_done err=%b rw=%b req=%b stall=%b exp 1 0 0 0",
               mem_err_o, RegWrite_o, bus_req_o, mem_stall_o);
    end
    checks++;
    if (MemData_o !== 32'h0) begin
      errors++; $display("FAIL to_data got=%h exp=00000000", MemData_o);
    end
    tick;
    set_idle;
    #1;
    checks++;
    if (mem_err_o !== 1'b0) begin
      errors++; $display("FAIL to_clear got=%b exp=0", mem_err_o);
    end
  endtask

  task automatic test_rst_mid;
    set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h500, 32'h0);
    tick;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus_req_o !== 1'b0) begin
      errors++; $display("FAIL rst_async_req got=%b exp=0", bus_req_o);
    end
    set_idle;
    tick;
    tick;
    rst = 1'b0;
    #1;
    checks++;
    if ({bus_req_o, mem_stall_o} !== 2'b00) begin
      errors++; $display("FAIL rst_idle req=%b stall=%b exp 0 0", bus_req_o, mem_stall_o);
    end
    tick;
    set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h500, 32'h0);
    tick;
    bus_rdata_i = 32'hDEAD_BEEF;
    bus_ack_i   = 1'b1;
    tick;
    bus_ack_i = 1'b0;
    checks++;
    if (MemData_o !== 32'hDEAD_BEEF || mem_stall_o !== 1'b0 || mem_err_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_next_lw mdata=%h stall=%b err=%b exp deadbeef 0 0",
               MemData_o, mem_stall_o, mem_err_o);
    end
    tick;
    set_idle;
  endtask

  task automatic test_lhu_misalign;
    set_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h301, 32'h0);
    tick;
`ifdef MEM_ALIGN_CHECK_EN
    checks++;
    if ({misalign_o, bus_req_o, RegWrite_o, mem_stall_o} !== 4'b1000) begin
      errors++;
      $display("FAIL lhu_mis mis=%b req=%b rw=%b stall=%b exp 1 0 0 0",
               misalign_o, bus_req_o, RegWrite_o, mem_stall_o);
    end
    checks++;
    if (MemData_o !== 32'h0) begin
      errors++; $display("FAIL lhu_mis_data got=%h exp=00000000", MemData_o);
    end
    tick;
    set_idle;
`else
    checks++;
    if (bus_be_o !== 4'b0011 || bus_req_o !== 1'b1 || bus_addr_o !== 32'h300) begin
      errors++;
      $display("FAIL lhu_be be=%b req=%b addr=%h exp 0011 1 00000300", bus_be_o, bus_req_o, bus_addr_o);
    end
    bus_rdata_i = 32'h1234_F00D;
    bus_ack_i   = 1'b1;
    tick;
    bus_ack_i = 1'b0;
    checks++;
    if (MemData_o !== 32'h0000_F00D || misalign_o !== 1'b0 || RegWrite_o !== 1'b1) begin
      errors++;
      $display("FAIL lhu_data mdata=%h mis=%b rw=%b exp 0000f00d 0 1", MemData_o, misalign_o, RegWrite_o);
    end
    tick;
    set_idle;
`endif
  endtask

  task automatic test_back_to_back;
    set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h600, 32'h0);
    tick;
    bus_rdata_i = 32'h1122_3344;
    bus_ack_i   = 1'b1;
    tick;
    bus_ack_i = 1'b0;
    checks++;
    if (MemData_o !== 32'h1122_3344 || mem_stall_o !== 1'b0) begin
      errors++; $display("FAIL b2b_lw mdata=%h stall=%b exp 11223344 0", MemData_o, mem_stall_o);
    end
    tick;
    set_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h604, 32'h55);
    #1;
    checks++;
    if (mem_stall_o !== 1'b1) begin
      errors++; $display("FAIL b2b_sw_stall got=%b exp=1", mem_stall_o);
    end
    tick;
    checks++;
    if ({bus_req_o, bus_we_o, bus_be_o} !== 6'b11_1111 ||
        bus_addr_o !== 32'h604 || bus_wdata_o !== 32'h55) begin
      errors++;
      $display("FAIL b2b_sw_bus req=%b we=%b be=%b addr=%h wdata=%h exp 1 1 1111 00000604 00000055",
               bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o);
    end
    bus_ack_i = 1'b1;
    tick;
    bus_ack_i = 1'b0;
    checks++;
    if ({mem_stall_o, bus_req_o, mem_err_o} !== 3'b000) begin
      errors++;
      $display("FAIL b2b_sw_done stall=%b req=%b err=%b exp 0 0 0", mem_stall_o, bus_req_o, mem_err_o);
    end
    tick;
    set_idle;
    bus_rdata_i = 32'hFFFF_FFFF;
    bus_ack_i   = 1'b1;
    tick;
    bus_ack_i = 1'b0;
    checks++;
    if (MemData_o !== 32'h1122_3344 || bus_req_o !== 1'b0 || mem_stall_o !== 1'b0) begin
      errors++;
      $display("FAIL stray_ack mdata=%h req=%b stall=%b exp 11223344 0 0",
               MemData_o, bus_req_o, mem_stall_o);
    end
  endtask

  initial begin
    test_reset;
    test_lb;
    test_sh;
    test_timeout;
    test_rst_mid;
    test_lhu_misalign;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
